// File: rtl/traffic_pkg.sv
// Purpose: shared phase codes, requester indices and arbiter state for the traffic request path.
// Latency: none (types, constants and a pure helper function only).
// Backpressure: not applicable.
package traffic_pkg;

  // Phase codes presented to the light sequencer on grant_phase.
  localparam logic [1:0] PHASE_NONE    = 2'd0;
  localparam logic [1:0] PHASE_LEFT    = 2'd1;
  localparam logic [1:0] PHASE_NS_WALK = 2'd2;
  localparam logic [1:0] PHASE_EW_WALK = 2'd3;

  // Requester indices; these double as bit positions in the pending vector.
  localparam logic [1:0] REQ_LEFT    = 2'd0;
  localparam logic [1:0] REQ_NS_WALK = 2'd1;
  localparam logic [1:0] REQ_EW_WALK = 2'd2;
  localparam int         NUM_REQ     = 3;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_OFFER  = 2'd1,
    ARB_ACTIVE = 2'd2
  } arb_state_e;

  // Requester index to the phase code the sequencer understands.
  function automatic logic [1:0] req_to_phase(input logic [1:0] idx);
    case (idx)
      REQ_LEFT:    return PHASE_LEFT;
      REQ_NS_WALK: return PHASE_NS_WALK;
      REQ_EW_WALK: return PHASE_EW_WALK;
      default:     return PHASE_NONE;
    endcase
  endfunction

  // Next requester index, wrapping 2 -> 0.
  function automatic logic [1:0] req_next(input logic [1:0] idx);
    return (idx == REQ_EW_WALK) ? REQ_LEFT : idx + 2'd1;
  endfunction

endpackage

// File: rtl/button_sync_edge.sv
// Purpose: synchronise one asynchronous active-low pushbutton and flag its press (falling edge).
// Latency: button first sampled low at edge k -> press high for the cycle after edge k+SYNC_STAGES-1.
// Backpressure: none; a press is a single-cycle pulse and must be captured by the consumer.
module button_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic not_reset,
  input  logic button_n,
  output logic press
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchroniser chain plus previous-value flop; everything resets to "released" so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (!not_reset) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], button_n};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign press = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/phase_request_arbiter.sv
// Purpose: latch button requests and offer one optional phase per cycle boundary, round-robin.
// Latency: press -> pending in SYNC_STAGES edges; boundary -> grant 1 cycle; ack/done -> effect 1 cycle.
// Backpressure: an offer is held until phase_ack; further boundaries are ignored until phase_done.
module phase_request_arbiter
  import traffic_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_27,
  input  logic       not_reset,
  input  logic       not_southbound_left_request,
  input  logic       not_ns_walk_request,
  input  logic       not_ew_walk_request,
  input  logic       cycle_boundary,
  input  logic       phase_ack,
  input  logic       phase_done,
  output logic       grant_valid,
  output logic [1:0] grant_phase,
  output logic [2:0] pending,
  output logic       walk_request_waiting
);

  logic [NUM_REQ-1:0] press;
  logic [NUM_REQ-1:0] buttons_n;

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [1:0]         rr_ptr_q, rr_ptr_d;
  logic               grant_valid_q, grant_valid_d;
  logic [1:0]         grant_phase_q, grant_phase_d;

  logic [1:0]         sel_idx;
  logic               sel_found;
  logic [1:0]         cand;
  logic [1:0]         granted_idx;

  assign buttons_n[REQ_LEFT]    = not_southbound_left_request;
  assign buttons_n[REQ_NS_WALK] = not_ns_walk_request;
  assign buttons_n[REQ_EW_WALK] = not_ew_walk_request;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_btn
    button_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_btn (
      .clk      (clk_27),
      .not_reset(not_reset),
      .button_n (buttons_n[g]),
      .press    (press[g])
    );
  end

  // The offered code is always a live requester, so the granted index is recoverable from it.
  assign granted_idx = grant_phase_q - 2'd1;

  // Round-robin pick: first pending requester starting at rr_ptr and wrapping.
  always_comb begin
    sel_idx   = REQ_LEFT;
    sel_found = 1'b0;
    cand      = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!sel_found && pending_q[cand]) begin
        sel_idx   = cand;
        sel_found = 1'b1;
      end
      cand = req_next(cand);
    end
  end

  // Offer/ack/done handshake; a press landing on the ack edge re-sets the bit after the clear.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    rr_ptr_d      = rr_ptr_q;
    grant_valid_d = grant_valid_q;
    grant_phase_d = grant_phase_q;
    case (state_q)
      ARB_IDLE: begin
        if (cycle_boundary && sel_found) begin
          grant_phase_d = req_to_phase(sel_idx);
          grant_valid_d = 1'b1;
          state_d       = ARB_OFFER;
        end
      end
      ARB_OFFER: begin
        if (phase_ack) begin
          grant_valid_d          = 1'b0;
          pending_d[granted_idx] = 1'b0;
          rr_ptr_d               = req_next(granted_idx);
          state_d                = ARB_ACTIVE;
        end
      end
      ARB_ACTIVE: begin
        if (phase_done) begin
          grant_phase_d = PHASE_NONE;
          state_d       = ARB_IDLE;
        end
      end
      default: begin
        grant_valid_d = 1'b0;
        grant_phase_d = PHASE_NONE;
        state_d       = ARB_IDLE;
      end
    endcase
    pending_d = pending_d | press;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_27) begin
    if (!not_reset) begin
      state_q       <= ARB_IDLE;
      pending_q     <= '0;
      rr_ptr_q      <= REQ_LEFT;
      grant_valid_q <= 1'b0;
      grant_phase_q <= PHASE_NONE;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_valid_q <= grant_valid_d;
      grant_phase_q <= grant_phase_d;
    end
  end

  assign grant_valid          = grant_valid_q;
  assign grant_phase          = grant_phase_q;
  assign pending              = pending_q;
  assign walk_request_waiting = pending_q[REQ_NS_WALK] | pending_q[REQ_EW_WALK];

endmodule
